// File: rtl/rmst_tile_pkg.sv
// Shared types and helpers for the strided tile loader: FSM state encoding
// and the burst sizing rule.
package rmst_tile_pkg;

   localparam int unsigned NUM_STATES = 4;
   localparam int unsigned STATE_W    = $clog2(NUM_STATES);

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   function automatic int unsigned burst_len(input int unsigned blen,
                                             input int unsigned remaining);
      return (remaining < blen) ? remaining : blen;
   endfunction

endpackage

// File: rtl/rmst_beat_unpacker.sv
// Splits XDW-bit read-master beats into DW-bit RAM writes, one word per cycle,
// with a running RAM address that wraps at 2^AW.
module rmst_beat_unpacker #(
   parameter int XDW = 128,
   parameter int DW  = 32,
   parameter int AW  = 12
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic [AW-1:0]  base,
   input  logic           pop_en,
   input  logic           avail,
   input  logic [XDW-1:0] data,
   output logic           pop,
   output logic           wr_ena,
   output logic [AW-1:0]  wr_addr,
   output logic [DW-1:0]  wr_data
);

   localparam int WCNT = XDW / DW;

   logic [XDW-1:0]  beat_q, beat_d;
   logic            full_q, full_d;
   logic [WCNT-1:0] ptr_q, ptr_d;
   logic            wr_ena_q, wr_ena_d;
   logic [AW-1:0]   wr_addr_q, wr_addr_d;
   logic [AW-1:0]   nxt_q, nxt_d;
   logic [DW-1:0]   wr_data_q, wr_data_d;
   logic [DW-1:0]   sel;

   // Word 0 is written straight from the FIFO head in the pop cycle, so the
   // beat register only has to hold words 1..WCNT-1; the next pop lands on the
   // cycle after the last of those, keeping one write per cycle.
   always_comb begin
      beat_d    = beat_q;
      full_d    = full_q;
      ptr_d     = ptr_q;
      wr_ena_d  = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      nxt_d     = nxt_q;
      sel       = '0;
      for (int k = 0; k < WCNT; k++) begin
         if (ptr_q[k]) sel = sel | beat_q[k*DW +: DW];
      end
      pop = pop_en && avail && !full_q;
      if (load) nxt_d = base;
      if (pop) begin
         beat_d    = data;
         full_d    = 1'b1;
         ptr_d     = WCNT'(2);
         wr_ena_d  = 1'b1;
         wr_data_d = data[DW-1:0];
         wr_addr_d = nxt_q;
         nxt_d     = nxt_q + AW'(1);
      end else if (full_q) begin
         wr_ena_d  = 1'b1;
         wr_data_d = sel;
         wr_addr_d = nxt_q;
         nxt_d     = nxt_q + AW'(1);
         ptr_d     = ptr_q << 1;
         if (ptr_q[WCNT-1]) full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q    <= 1'b0;
         ptr_q     <= '0;
         wr_ena_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         nxt_q     <= '0;
      end else begin
         full_q    <= full_d;
         ptr_q     <= ptr_d;
         wr_ena_q  <= wr_ena_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         nxt_q     <= nxt_d;
      end
   end

   always_ff @(posedge clk) begin
      beat_q <= beat_d;
   end

   assign wr_ena  = wr_ena_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;

endmodule

// File: rtl/rmst_tile_loader.sv
// Fetches a rows x row_len strided tile through the Avalon read master as
// row-bounded bursts and writes it densely into the tile RAM.
module rmst_tile_loader
   import rmst_tile_pkg::*;
#(
   parameter int DW         = 32,
   parameter int XDW        = 128,
   parameter int WCNT       = XDW / DW,
   parameter int AW         = 12,
   parameter int XAW        = 32,
   parameter int CW         = 8,
   parameter int RW         = 10,
   parameter int BLEN       = 8,
   parameter int FIFO_WORDS = 64
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cfg_valid,
   input  logic [XAW-1:0] cfg_raddr,
   input  logic [RW-1:0]  cfg_rows,
   input  logic [AW-1:0]  cfg_row_len,
   input  logic [XAW-1:0] cfg_row_stride,
   input  logic [AW-1:0]  cfg_ram_base,
   input  logic           start,
   output logic           busy,
   output logic           done,
   output logic           cfg_err,
   output logic           rmst_fixed_location,
   output logic [XAW-1:0] rmst_read_base,
   output logic [CW-1:0]  rmst_read_length,
   output logic           rmst_go,
   input  logic           rmst_done,
   output logic           rmst_user_read_buffer,
   input  logic [XDW-1:0] rmst_user_buffer_data,
   input  logic           rmst_user_data_available,
   output logic           ram_wr_ena,
   output logic [AW-1:0]  ram_wr_addr,
   output logic [DW-1:0]  ram_wr_data
);

   localparam int OW = AW + 1;

   state_e         state_q, state_d;
   logic           cfg_err_q, cfg_err_d;
   logic           go_prev_q, go_prev_d;
   logic [OW-1:0]  outs_q, outs_d;
   logic [OW-1:0]  infl_q, infl_d;
   logic [AW-1:0]  col_q, col_d;
   logic [RW-1:0]  row_idx_q, row_idx_d;
   logic [XAW-1:0] raddr_q, raddr_d, stride_q, stride_d;
   logic [XAW-1:0] row_addr_q, row_addr_d, burst_addr_q, burst_addr_d;
   logic [RW-1:0]  rows_q, rows_d;
   logic [AW-1:0]  row_len_q, row_len_d, ram_base_q, ram_base_d;
   logic [AW-1:0]  len;
   logic [31:0]    len_bytes;
   logic           go, credit_ok, row_end, last_burst, accept, pop, wr_ena;

   always_comb begin
      state_d      = state_q;
      cfg_err_d    = cfg_err_q;
      col_d        = col_q;
      row_idx_d    = row_idx_q;
      raddr_d      = raddr_q;
      stride_d     = stride_q;
      rows_d       = rows_q;
      row_len_d    = row_len_q;
      ram_base_d   = ram_base_q;
      row_addr_d   = row_addr_q;
      burst_addr_d = burst_addr_q;

      len        = AW'(burst_len(BLEN, 32'(row_len_q - col_q)));
      len_bytes  = 32'(len) * 32'(DW / 8);
      credit_ok  = (32'(outs_q) + 32'(len)) <= 32'(FIFO_WORDS);
      go         = (state_q == ISSUE) && rmst_done && !go_prev_q && credit_ok;
      row_end    = (col_q + len) == row_len_q;
      last_burst = row_end && (row_idx_q == rows_q - RW'(1));
      accept     = (state_q == IDLE) && start && !cfg_err_q;
      go_prev_d  = go;

      // Credits count words requested but not yet written; infl counts words
      // requested but not yet popped, so stray beats are never consumed.
      outs_d = outs_q + (go ? OW'(len) : '0) - (wr_ena ? OW'(1) : '0);
      infl_d = infl_q + (go ? OW'(len) : '0) - (pop ? OW'(WCNT) : '0);

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d      = ISSUE;
               row_addr_d   = raddr_q;
               burst_addr_d = raddr_q;
               col_d        = '0;
               row_idx_d    = '0;
            end
         end
         ISSUE: begin
            if (go) begin
               if (row_end) begin
                  col_d        = '0;
                  row_idx_d    = row_idx_q + RW'(1);
                  row_addr_d   = row_addr_q + stride_q;
                  burst_addr_d = row_addr_q + stride_q;
                  if (last_burst) state_d = DRAIN;
               end else begin
                  col_d        = col_q + len;
                  burst_addr_d = burst_addr_q + XAW'(len_bytes);
               end
            end
         end
         DRAIN: begin
            if (wr_ena && outs_q == OW'(1)) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (cfg_valid && (state_q == IDLE || state_q == DONE)) begin
         raddr_d    = cfg_raddr;
         rows_d     = cfg_rows;
         row_len_d  = cfg_row_len;
         stride_d   = cfg_row_stride;
         ram_base_d = cfg_ram_base;
         cfg_err_d  = ((cfg_row_len % AW'(WCNT)) != '0) || (cfg_row_len == '0) ||
                      (cfg_rows == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cfg_err_q <= 1'b0;
         go_prev_q <= 1'b0;
         outs_q    <= '0;
         infl_q    <= '0;
         col_q     <= '0;
         row_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         cfg_err_q <= cfg_err_d;
         go_prev_q <= go_prev_d;
         outs_q    <= outs_d;
         infl_q    <= infl_d;
         col_q     <= col_d;
         row_idx_q <= row_idx_d;
      end
   end

   always_ff @(posedge clk) begin
      raddr_q      <= raddr_d;
      stride_q     <= stride_d;
      rows_q       <= rows_d;
      row_len_q    <= row_len_d;
      ram_base_q   <= ram_base_d;
      row_addr_q   <= row_addr_d;
      burst_addr_q <= burst_addr_d;
   end

   rmst_beat_unpacker #(
      .XDW (XDW),
      .DW  (DW),
      .AW  (AW)
   ) u_unpacker (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .base    (ram_base_q),
      .pop_en  (infl_q != '0),
      .avail   (rmst_user_data_available),
      .data    (rmst_user_buffer_data),
      .pop     (pop),
      .wr_ena  (wr_ena),
      .wr_addr (ram_wr_addr),
      .wr_data (ram_wr_data)
   );

   assign busy                  = (state_q == ISSUE) || (state_q == DRAIN);
   assign done                  = (state_q == DONE);
   assign cfg_err               = cfg_err_q;
   assign rmst_fixed_location   = 1'b0;
   assign rmst_go               = go;
   assign rmst_read_base        = (state_q == ISSUE) ? burst_addr_q : '0;
   assign rmst_read_length      = (state_q == ISSUE) ? CW'(len_bytes) : '0;
   assign rmst_user_read_buffer = pop;
   assign ram_wr_ena            = wr_ena;

endmodule
